// File: rtl/pwm_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_frame_ctrl_if
// Bundles the serial byte input and the PWM/status outputs of pwm_frame_ctrl.
//   rx_data      8 bits     received byte (source -> controller)
//   new_rx_data  1 bit      byte-valid flag, a rising edge marks one byte
//   pwm          CHANNELS   PWM outputs (controller -> sink)
//   frame_ok     1 bit      pulse: frame accepted into shadow
//   frame_err    1 bit      pulse: checksum mismatch or inter-byte timeout
//   busy         1 bit      frame reception in progress
//   pending      1 bit      shadow holds a frame not yet applied
// master = byte source / observer, slave = pwm_frame_ctrl.
// ---------------------------------------------------------------------------
interface pwm_frame_ctrl_if #(
  parameter int CHANNELS = 11
);
  logic [7:0]          rx_data;
  logic                new_rx_data;
  logic [CHANNELS-1:0] pwm;
  logic                frame_ok;
  logic                frame_err;
  logic                busy;
  logic                pending;

  modport master (
    output rx_data, new_rx_data,
    input  pwm, frame_ok, frame_err, busy, pending
  );

  modport slave (
    input  rx_data, new_rx_data,
    output pwm, frame_ok, frame_err, busy, pending
  );
endinterface

// File: rtl/pwm_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_frame_ctrl
// Multi-channel PWM generator whose duties arrive as framed bytes:
//   SYNC_BYTE, CHANNELS*BPC big-endian duty bytes (ch0 first), 8-bit sum.
// Good frames land in a shadow bank; the shadow is copied to the active
// duties only in the last cycle of a PWM period, so all channels switch
// together on a period boundary. Bad or stalled frames are dropped.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  pwm_frame_ctrl_if.slave (rx_data/new_rx_data in; pwm, frame_ok,
//        frame_err, busy, pending out -- all outputs registered)
// ---------------------------------------------------------------------------
module pwm_frame_ctrl #(
  parameter int         CHANNELS  = 11,
  parameter int         WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  pwm_frame_ctrl_if.slave   bus
);

  localparam int BPC = (WIDTH + 7) / 8;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                new_rx_data_q;
  logic [CW-1:0]       ch_q, ch_d;
  logic [SW-1:0]       sub_q, sub_d;
  logic [7:0]          sum_q, sum_d;
  logic [TW-1:0]       gap_q, gap_d;
  logic [WIDTH-1:0]    rx_buf_q [CHANNELS];
  logic [WIDTH-1:0]    rx_buf_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic                pending_q, pending_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                frame_ok_q, frame_ok_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  logic                byte_stb_s;
  logic                commit_s;
  logic                apply_s;
  logic [WIDTH+7:0]    asm_s;

  // Next-state logic: byte framing FSM, shadow/active banks, counter, outputs.
  always_comb begin
    byte_stb_s  = bus.new_rx_data & ~new_rx_data_q;
    state_d     = state_q;
    ch_d        = ch_q;
    sub_d       = sub_q;
    sum_d       = sum_q;
    gap_d       = gap_q;
    rx_buf_d    = rx_buf_q;
    shadow_d    = shadow_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    commit_s    = 1'b0;
    // Shift the new byte in from the right; after BPC bytes any stale or
    // surplus high bits have fallen off the WIDTH-bit register.
    asm_s       = {rx_buf_q[ch_q], bus.rx_data};

    case (state_q)
      IDLE: begin
        if (byte_stb_s && (bus.rx_data == SYNC_BYTE)) begin
          state_d = DATA;
          ch_d    = {CW{1'b0}};
          sub_d   = {SW{1'b0}};
          sum_d   = 8'd0;
          gap_d   = {TW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (byte_stb_s) begin
          rx_buf_d[ch_q] = asm_s[WIDTH-1:0];
          sum_d          = sum_q + bus.rx_data;
          gap_d          = {TW{1'b0}};
          if (sub_q == SW'(BPC - 1)) begin
            sub_d = {SW{1'b0}};
            if (ch_q == CW'(CHANNELS - 1)) begin
              ch_d    = {CW{1'b0}};
              state_d = CHECK;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end else if (gap_q == TW'(TIMEOUT - 1)) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          gap_d = gap_q + TW'(1);
        end
      end

      CHECK: begin
        if (byte_stb_s) begin
          state_d = IDLE;
          if (bus.rx_data == sum_q) begin
            shadow_d   = rx_buf_q;
            commit_s   = 1'b1;
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (gap_q == TW'(TIMEOUT - 1)) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          gap_d = gap_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Apply uses the registered pending flag, so a frame committed in the
    // all-ones cycle itself waits for the next boundary.
    apply_s = pending_q && (cnt_q == {WIDTH{1'b1}});
    if (apply_s) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end

    // A fresh commit always leaves pending set, even if an apply of the
    // previous shadow happens in the same cycle.
    if (commit_s) begin
      pending_d = 1'b1;
    end else if (apply_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    cnt_d = cnt_q + WIDTH'(1);

    for (int n = 0; n < CHANNELS; n++) begin
      pwm_d[n] = (active_q[n] > cnt_q);
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      new_rx_data_q <= 1'b0;
      ch_q          <= {CW{1'b0}};
      sub_q         <= {SW{1'b0}};
      sum_q         <= 8'd0;
      gap_q         <= {TW{1'b0}};
      rx_buf_q      <= '{default: {WIDTH{1'b0}}};
      shadow_q      <= '{default: {WIDTH{1'b0}}};
      active_q      <= '{default: {WIDTH{1'b0}}};
      pending_q     <= 1'b0;
      cnt_q         <= {WIDTH{1'b0}};
      pwm_q         <= {CHANNELS{1'b0}};
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      new_rx_data_q <= bus.new_rx_data;
      ch_q          <= ch_d;
      sub_q         <= sub_d;
      sum_q         <= sum_d;
      gap_q         <= gap_d;
      rx_buf_q      <= rx_buf_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.pwm       = pwm_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_frame_ctrl
// Directed bench for pwm_frame_ctrl. dut1: 11 channels x 8 bits,
// dut2: 2 channels x 12 bits; both use a short TIMEOUT. Bytes are driven on
// the falling edge and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_frame_ctrl;

  localparam int TMO = 300;

  logic       clk;
  logic       rst;
  logic [7:0] rx_d;
  logic       new_d;
  int         sel_r;
  int         tb_cyc;
  int         errors;
  int         checks;
  int         hi1 [11];
  int         hi2 [2];

  pwm_frame_ctrl_if #(.CHANNELS(11)) if1 ();
  pwm_frame_ctrl_if #(.CHANNELS(2))  if2 ();

  assign if1.rx_data     = rx_d;
  assign if2.rx_data     = rx_d;
  assign if1.new_rx_data = new_d & (sel_r == 0);
  assign if2.new_rx_data = new_d & (sel_r == 1);

  pwm_frame_ctrl #(.CHANNELS(11), .WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  pwm_frame_ctrl #(.CHANNELS(2), .WIDTH(12), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count since reset release; its low 8 bits track dut1's counter.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(negedge clk);
    sel_r = sel;
    rx_d  = b;
    new_d = 1'b1;
    @(negedge clk);
    new_d = 1'b0;
  endtask

  task automatic wait_pending_clear(input int sel, input int max, input string tag);
    int k;
    k = 0;
    while (((sel == 0) ? if1.pending : if2.pending) && (k < max)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (sel == 0) ? if1.pending : if2.pending, 1'b0);
  endtask

  task automatic wait_cnt(input int target, input string tag);
    int k;
    k = 0;
    while (((tb_cyc % 256) != target) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, tb_cyc % 256, target);
  endtask

  task automatic count1(input int cycles);
    for (int c = 0; c < 11; c++) hi1[c] = 0;
    for (int i = 0; i < cycles; i++) begin
      for (int c = 0; c < 11; c++) hi1[c] += int'(if1.pwm[c]);
      @(negedge clk);
    end
  endtask

  task automatic count2(input int cycles);
    for (int c = 0; c < 2; c++) hi2[c] = 0;
    for (int i = 0; i < cycles; i++) begin
      for (int c = 0; c < 2; c++) hi2[c] += int'(if2.pwm[c]);
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel_r  = 0;
    rx_d   = 8'h00;
    new_d  = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_pwm1",    if1.pwm, 11'h000);
    chk("rst_busy1",   if1.busy, 1'b0);
    chk("rst_pend1",   if1.pending, 1'b0);
    chk("rst_ok1",     if1.frame_ok, 1'b0);
    chk("rst_err1",    if1.frame_err, 1'b0);
    chk("rst_pwm2",    if2.pwm, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: duties 0x00,0x10..0xA0, checksum 0x70
    send_byte(0, 8'hA5);
    chk("t1_busy", if1.busy, 1'b1);
    for (int k = 0; k < 11; k++) send_byte(0, 8'(16 * k));
    send_byte(0, 8'h70);
    chk("t1_ok",   if1.frame_ok, 1'b1);
    chk("t1_err",  if1.frame_err, 1'b0);
    chk("t1_pend", if1.pending, 1'b1);
    chk("t1_busy0", if1.busy, 1'b0);
    @(negedge clk);
    chk("t1_ok_pulse", if1.frame_ok, 1'b0);
    wait_pending_clear(0, 300, "t1_apply");
    repeat (2) @(negedge clk);
    count1(256);
    for (int k = 0; k < 11; k++) chk($sformatf("t1_duty_ch%0d", k), hi1[k], 16 * k);

    // 2: same frame, bad checksum 0x71
    send_byte(0, 8'hA5);
    for (int k = 0; k < 11; k++) send_byte(0, 8'(16 * k));
    send_byte(0, 8'h71);
    chk("t2_err",  if1.frame_err, 1'b1);
    chk("t2_ok",   if1.frame_ok, 1'b0);
    chk("t2_pend", if1.pending, 1'b0);
    @(negedge clk);
    chk("t2_err_pulse", if1.frame_err, 1'b0);
    repeat (260) @(negedge clk);
    chk("t2_pend_later", if1.pending, 1'b0);
    count1(256);
    chk("t2_duty_ch10", hi1[10], 160);
    chk("t2_duty_ch1",  hi1[1], 16);

    // 3: partial frame then silence -> timeout after TMO cycles
    send_byte(0, 8'hA5);
    for (int k = 0; k < 5; k++) send_byte(0, 8'h55);
    repeat (TMO - 1) @(negedge clk);
    chk("t3_err_early", if1.frame_err, 1'b0);
    chk("t3_busy",      if1.busy, 1'b1);
    @(negedge clk);
    chk("t3_err",       if1.frame_err, 1'b1);
    chk("t3_busy0",     if1.busy, 1'b0);
    chk("t3_pend",      if1.pending, 1'b0);

    // 4: ch3 data byte equals sync value; all others 0x20, checksum 0xE5
    send_byte(0, 8'hA5);
    for (int k = 0; k < 11; k++) send_byte(0, (k == 3) ? 8'hA5 : 8'h20);
    send_byte(0, 8'hE5);
    chk("t4_ok", if1.frame_ok, 1'b1);
    wait_pending_clear(0, 300, "t4_apply");
    repeat (2) @(negedge clk);
    count1(256);
    chk("t4_duty_ch3",  hi1[3], 165);
    chk("t4_duty_ch0",  hi1[0], 32);
    chk("t4_duty_ch10", hi1[10], 32);

    // 5a: commit in the cnt==0xFF cycle, all duties 0x40, checksum 0xC0
    send_byte(0, 8'hA5);
    for (int k = 0; k < 11; k++) send_byte(0, 8'h40);
    wait_cnt(254, "t5_align");
    send_byte(0, 8'hC0);
    chk("t5_ok",   if1.frame_ok, 1'b1);
    chk("t5_pend", if1.pending, 1'b1);
    count1(256);
    chk("t5_old_duty_ch0", hi1[0], 32);
    chk("t5_pend_clear",   if1.pending, 1'b0);
    repeat (2) @(negedge clk);
    count1(256);
    chk("t5_new_duty_ch0", hi1[0], 64);

    // 5b: two frames in one period, last one wins
    wait_cnt(16, "t5b_align");
    send_byte(0, 8'hA5);
    for (int k = 0; k < 11; k++) send_byte(0, 8'h08);
    send_byte(0, 8'h58);
    chk("t5b_ok_a", if1.frame_ok, 1'b1);
    send_byte(0, 8'hA5);
    for (int k = 0; k < 11; k++) send_byte(0, 8'h30);
    send_byte(0, 8'h10);
    chk("t5b_ok_b", if1.frame_ok, 1'b1);
    chk("t5b_pend", if1.pending, 1'b1);
    wait_pending_clear(0, 300, "t5b_apply");
    repeat (2) @(negedge clk);
    count1(256);
    chk("t5b_duty_ch5", hi1[5], 48);
    chk("t5b_duty_ch0", hi1[0], 48);

    // 6: 12-bit, 2-channel instance
    send_byte(1, 8'hA5);
    send_byte(1, 8'h0F);
    send_byte(1, 8'hFF);
    send_byte(1, 8'h00);
    send_byte(1, 8'h01);
    send_byte(1, 8'h0F);
    chk("t6_ok",  if2.frame_ok, 1'b1);
    chk("t6_dut1_quiet", if1.busy, 1'b0);
    wait_pending_clear(1, 4200, "t6_apply");
    repeat (2) @(negedge clk);
    count2(4096);
    chk("t6_duty_ch0", hi2[0], 4095);
    chk("t6_duty_ch1", hi2[1], 1);

    // Reset mid-frame on a running PWM
    send_byte(0, 8'hA5);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    chk("rmid_busy", if1.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rmid_busy0", if1.busy, 1'b0);
    chk("rmid_pwm1",  if1.pwm, 11'h000);
    chk("rmid_pwm2",  if2.pwm, 2'b00);
    chk("rmid_pend",  if1.pending, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("rmid_busy_after", if1.busy, 1'b0);
    count1(256);
    chk("rmid_duty_ch5", hi1[5], 0);
    chk("rmid_duty_ch0", hi1[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
